sync_updown_counter_param: RTL and testbench
============================================

Name: sync_updown_counter_param

Overview:
Parametrised synchronous up/down counter. It succeeds the fixed 5-bit up/down counter and adds configurable width, modulus, synchronous parallel load, count enable, wrap/saturate mode, a cascade terminal-count output and an overflow/underflow flag. The block is used as a general event/timing counter and can be chained through tc to build wider counters.

Parameters:
WIDTH, 8, counter width in bits (2..32).
MODULUS, 2**WIDTH, count range 0..MODULUS-1; must satisfy 2 <= MODULUS <= 2**WIDTH.
SATURATE, 0, 0 = wrap at range ends; 1 = hold at range ends.

Ports:
clk  input  1  rising-edge clock.
clr  input  1  asynchronous, active-high reset.
en  input  1  count enable; ignored while load=1.
mode  input  1  0 = count up, 1 = count down.
load  input  1  synchronous parallel load strobe.
din  input  WIDTH  load value.
q  output  WIDTH  registered count.
qbar  output  WIDTH  bitwise complement of q (combinational from q).
tc  output  1  terminal count, combinational: en & ~load & ((~mode & q==MODULUS-1) | (mode & q==0)).
ovf  output  1  registered one-cycle pulse on a boundary event.

Behaviour:
- Reset: clr=1 forces q=0 and ovf=0 immediately, independent of clk. It therefore forces qbar to all-ones. While clr is held, all other inputs are ignored. The first count edge after clr deasserts acts on q=0.
- Priority at each rising clk edge: clr > load > en > hold.
- Load:
  - load=1 sets q <= din when din <= MODULUS-1. Otherwise q <= MODULUS-1 (clamp).
  - ovf <= 0 on a load cycle.
  - Load takes effect regardless of en.
- Count: when en=1 and load=0:
  - Up: q <= q+1 when q < MODULUS-1.
  - Down: q <= q-1 when q > 0.
- Boundary, up at q==MODULUS-1:
  - SATURATE=0: q <= 0 and ovf <= 1.
  - SATURATE=1: q holds and ovf <= 1.
- Boundary, down at q==0:
  - SATURATE=0: q <= MODULUS-1 and ovf <= 1.
  - SATURATE=1: q holds and ovf <= 1.
- ovf:
  - High for exactly the one cycle following a boundary step; cleared on the next edge unless another boundary step occurs.
  - With SATURATE=1 and en held at a range end, ovf stays high on every cycle the boundary step is attempted.
- Hold: with en=0 and load=0, q holds and ovf <= 0.
- mode is sampled at the edge only. A mode change between edges has no effect until the next counted edge, and there are no glitches on q.
- tc:
  - Combinational with zero latency. It is the carry/borrow for cascading: stage n+1's en = stage n's tc, with mode shared between stages.
  - tc is low whenever load=1.
- Out-of-range q cannot occur from reset or load. Arithmetic is confined to WIDTH bits with no intermediate overflow: compare against MODULUS-1 and never rely on natural wrap, except when MODULUS=2**WIDTH, where the results are identical.
- Single clock domain. No multicycle paths. All state lives in the q and ovf registers.

Test Plan:
1. WIDTH=4, MODULUS=10, SATURATE=0: assert clr mid-cycle with q=7. Required: q=0, qbar=4'hF, ovf=0 immediately, before any clk edge.
2. Same config, mode=0, en=1 from q=0: required sequence 0..9,0. ovf=1 only in the cycle after 9->0. tc=1 only while q=9.
3. Same config, mode=1, en=1 from q=2: required sequence 2,1,0,9,8. ovf pulses once after 0->9. tc=1 while q=0.
4. SATURATE=1, MODULUS=10: count up from 8 for 4 edges. Required: q=9,9,9,9 and ovf=0,1,1,1. Switch to mode=1: q=8 and ovf=0.
5. Load din=5 with en=1 and mode=0 on the same edge: required q=5, not 6. Load din=12 with MODULUS=10: required q=9. Hold en=0 for 3 edges: q stays 9 and ovf=0.
6. Two instances cascaded via tc, WIDTH=4, MODULUS=16: count up from 0x0F. Required: next value 0x10. Counting down from 0x10 yields 0x0F.

Source files
------------

// File: rtl/sync_updown_counter_param.sv
// Parametrised synchronous up/down counter with parallel load, count enable,
// wrap/saturate at the range ends, a cascade terminal-count output and a
// one-cycle boundary (overflow/underflow) flag.
module sync_updown_counter_param #(
  parameter int unsigned     WIDTH    = 8,
  parameter longint unsigned MODULUS  = 64'd1 << WIDTH,
  parameter bit              SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic             mode,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic             tc,
  output logic             ovf
);

  // Top of the count range; all range decisions compare against this so that
  // non-power-of-two moduli never depend on natural binary wrap.
  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 64'd1);

  logic [WIDTH-1:0] q_q, q_d;
  logic             ovf_q, ovf_d;
  logic             at_top, at_bottom, boundary;

  assign at_top    = (q_q == MAX_VAL);
  assign at_bottom = (q_q == '0);

  // A counted step in the current direction would cross a range end.
  assign boundary = mode ? at_bottom : at_top;

  // Next-state: load beats count, count beats hold; ovf marks boundary steps.
  always_comb begin
    q_d   = q_q;
    ovf_d = 1'b0;
    if (load) begin
      q_d = (din > MAX_VAL) ? MAX_VAL : din;
    end else if (en) begin
      if (boundary) begin
        ovf_d = 1'b1;
        if (!SATURATE) begin
          q_d = mode ? MAX_VAL : '0;
        end
      end else if (mode) begin
        q_d = q_q - WIDTH'(1);
      end else begin
        q_d = q_q + WIDTH'(1);
      end
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      q_q   <= '0;
      ovf_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      ovf_q <= ovf_d;
    end
  end

  assign q    = q_q;
  assign qbar = ~q_q;
  assign ovf  = ovf_q;

  // Carry/borrow for cascading: high when this edge would take a boundary step.
  assign tc = en & ~load & boundary;

endmodule

// File: tb/tb_sync_updown_counter_param.sv
// Self-checking bench: wrap and saturate counters (WIDTH=4, MODULUS=10) plus a
// two-stage cascade of modulus-16 counters, checked every cycle against an
// integer model and at key points against hand-computed values.
module tb_sync_updown_counter_param;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       en = 1'b0, mode = 1'b0, load = 1'b0;
  logic [3:0] din = '0;

  logic [3:0] a_q, a_qbar, b_q, b_qbar;
  logic       a_tc, a_ovf, b_tc, b_ovf;

  logic       c_en = 1'b0, c_mode = 1'b0, c_load = 1'b0;
  logic [7:0] c_din = '0;
  logic [3:0] lo_q, lo_qbar, hi_q, hi_qbar;
  logic       lo_tc, lo_ovf, hi_tc, hi_ovf;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  sync_updown_counter_param #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .clr(clr), .en(en), .mode(mode), .load(load), .din(din),
    .q(a_q), .qbar(a_qbar), .tc(a_tc), .ovf(a_ovf));

  sync_updown_counter_param #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b1)) u_sat (
    .clk(clk), .clr(clr), .en(en), .mode(mode), .load(load), .din(din),
    .q(b_q), .qbar(b_qbar), .tc(b_tc), .ovf(b_ovf));

  sync_updown_counter_param #(.WIDTH(4), .MODULUS(16), .SATURATE(1'b0)) u_lo (
    .clk(clk), .clr(clr), .en(c_en), .mode(c_mode), .load(c_load), .din(c_din[3:0]),
    .q(lo_q), .qbar(lo_qbar), .tc(lo_tc), .ovf(lo_ovf));

  sync_updown_counter_param #(.WIDTH(4), .MODULUS(16), .SATURATE(1'b0)) u_hi (
    .clk(clk), .clr(clr), .en(lo_tc), .mode(c_mode), .load(c_load), .din(c_din[7:4]),
    .q(hi_q), .qbar(hi_qbar), .tc(hi_tc), .ovf(hi_ovf));

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference step: move one unit in integer space, then decide what to do if
  // the result left 0..m-1.
  function automatic void step(input int cur, input bit e, input bit md, input bit ld,
                               input int d, input int m, input bit sat,
                               output int nq, output bit novf);
    int t;
    nq = cur;
    novf = 1'b0;
    if (ld) begin
      nq = (d > m - 1) ? m - 1 : d;
    end else if (e) begin
      t = md ? cur - 1 : cur + 1;
      if (t < 0 || t >= m) begin
        novf = 1'b1;
        nq = sat ? cur : (t + m) % m;
      end else begin
        nq = t;
      end
    end
  endfunction

  int ma_q = 0, mb_q = 0, mc_v = 0;
  bit ma_ovf = 1'b0, mb_ovf = 1'b0;

  always @(posedge clk or posedge clr) begin
    int nq;
    bit no;
    if (clr) begin
      ma_q = 0; ma_ovf = 1'b0;
      mb_q = 0; mb_ovf = 1'b0;
      mc_v = 0;
    end else begin
      step(ma_q, en, mode, load, int'(din), 10, 1'b0, nq, no);
      ma_q = nq; ma_ovf = no;
      step(mb_q, en, mode, load, int'(din), 10, 1'b1, nq, no);
      mb_q = nq; mb_ovf = no;
      if (c_load)    mc_v = int'(c_din);
      else if (c_en) mc_v = (mc_v + (c_mode ? 255 : 1)) % 256;
    end
  end

  // Per-cycle comparison, away from the active edge.
  always @(negedge clk) begin
    int nq;
    bit a_bnd, b_bnd;
    step(ma_q, en, mode, 1'b0, 0, 10, 1'b0, nq, a_bnd);
    step(mb_q, en, mode, 1'b0, 0, 10, 1'b1, nq, b_bnd);
    chk("wrap_q",    int'(a_q),    ma_q);
    chk("wrap_qbar", int'(a_qbar), 15 - ma_q);
    chk("wrap_ovf",  int'(a_ovf),  int'(ma_ovf));
    chk("wrap_tc",   int'(a_tc),   int'(a_bnd && !load));
    chk("sat_q",     int'(b_q),    mb_q);
    chk("sat_ovf",   int'(b_ovf),  int'(mb_ovf));
    chk("sat_tc",    int'(b_tc),   int'(b_bnd && !load));
    chk("casc_val",  int'({hi_q, lo_q}), mc_v);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tick();
    tick();
    clr = 1'b0;

    // Load 7, then clear mid-cycle: outputs must drop before any edge.
    load = 1'b1; din = 4'd7;
    tick();
    load = 1'b0;
    chk("load7_q", int'(a_q), 7);
    #2 clr = 1'b1;
    #1;
    chk("clr_q", int'(a_q), 0);
    chk("clr_qbar", int'(a_qbar), 15);
    chk("clr_ovf", int'(a_ovf), 0);
    tick();
    clr = 1'b0;

    // Count up through the wrap 9 -> 0.
    en = 1'b1; mode = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      chk("up_q", int'(a_q), i % 10);
      chk("up_ovf", int'(a_ovf), (i == 10) ? 1 : 0);
      chk("up_tc", int'(a_tc), (i == 9) ? 1 : 0);
    end
    tick();
    chk("up_ovf_clear", int'(a_ovf), 0);

    // Count down from 2 through the wrap 0 -> 9.
    en = 1'b0; load = 1'b1; din = 4'd2;
    tick();
    load = 1'b0; en = 1'b1; mode = 1'b1;
    #1 chk("dn_start_q", int'(a_q), 2);
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("dn_q", int'(a_q), (i == 1) ? 1 : (i == 2) ? 0 : (i == 3) ? 9 : 8);
      chk("dn_ovf", int'(a_ovf), (i == 3) ? 1 : 0);
      chk("dn_tc", int'(a_tc), (i == 2) ? 1 : 0);
    end

    // Saturating counter held at the top.
    en = 1'b0; load = 1'b1; din = 4'd8;
    tick();
    load = 1'b0; en = 1'b1; mode = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("sat_up_q", int'(b_q), 9);
      chk("sat_up_ovf", int'(b_ovf), (i == 1) ? 0 : 1);
    end
    mode = 1'b1;
    tick();
    chk("sat_dn_q", int'(b_q), 8);
    chk("sat_dn_ovf", int'(b_ovf), 0);

    // Load beats count; oversized load clamps; hold clears ovf.
    mode = 1'b0; en = 1'b1; load = 1'b1; din = 4'd5;
    tick();
    chk("load_pri_q", int'(a_q), 5);
    din = 4'd12;
    tick();
    chk("load_clamp_a", int'(a_q), 9);
    chk("load_clamp_b", int'(b_q), 9);
    din = 4'd3;
    #1 chk("tc_load_low", int'(a_tc), 0);
    load = 1'b0;
    #1 chk("tc_top_high", int'(a_tc), 1);
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_q", int'(a_q), 9);
      chk("hold_ovf", int'(a_ovf), 0);
    end

    // Cascade of two modulus-16 stages.
    c_load = 1'b1; c_din = 8'h0F;
    tick();
    c_load = 1'b0; c_en = 1'b1; c_mode = 1'b0;
    tick();
    chk("casc_up", int'({hi_q, lo_q}), 8'h10);
    c_mode = 1'b1;
    tick();
    chk("casc_dn", int'({hi_q, lo_q}), 8'h0F);
    c_load = 1'b1; c_din = 8'hFF; c_mode = 1'b0;
    tick();
    c_load = 1'b0;
    tick();
    chk("casc_wrap", int'({hi_q, lo_q}), 8'h00);
    for (int i = 0; i < 20; i++) begin
      c_mode = (i % 7 == 3);
      tick();
    end

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
